fetch_seq_ctrl: RTL and testbench
=================================

// Module: fetch_seq_ctrl
// PURPOSE
//  Owns the architectural PC and sequences instruction fetch for the miniRV core.
//  Computes next-PC with the same op encoding as the NPC stage: 00 seq, 01 jump, 10 cond branch, 11 hold.
//  Runs a req/ack handshake to instruction memory and hands each fetched word to decode with a valid/ready pair.
//  Handles redirects from execute, including killing an in-flight wrong-path fetch.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC fetched first after reset release
// PORTS
//  clk          in   1   core clock, all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  imem_req     out  1   fetch request to instruction memory
//  imem_addr    out  32  fetch address, word aligned
//  imem_ack     in   1   memory has returned imem_rdata this cycle
//  imem_rdata   in   32  fetched instruction word
//  inst_valid   out  1   inst/inst_pc/inst_pc4 hold a valid instruction
//  inst_ready   in   1   decode accepts the instruction
//  inst         out  32  instruction word
//  inst_pc      out  32  PC of inst
//  inst_pc4     out  32  inst_pc + 4, mod 2^32
//  redir_valid  in   1   execute presents a resolved control-flow instruction
//  redir_op     in   2   00 seq, 01 jump, 10 cond branch, 11 hold/halt
//  redir_br     in   1   branch condition result, used only when redir_op==10
//  redir_pc     in   32  PC of the redirecting instruction
//  redir_offset in   32  signed byte offset
//  halted       out  1   controller is in HALT
//  misalign_err out  1   one-cycle pulse: redirect target had [1:0]!=0
// BEHAVIOUR
//  Reset: state=BOOT, pc=RESET_PC; all outputs 0. inst, inst_pc and inst_pc4 are 32'h0.
//  Reset mid-request: the request is abandoned (imem_req drops asynchronously). Memory must drop any pending ack.
//  redir_take = redir_valid & (op==01 | (op==10 & redir_br)).
//  Target = redir_pc + redir_offset, mod 2^32.
//  If target[1:0]!=0: use target with [1:0] forced to 00 and pulse misalign_err.
//  Ops 00 and 10 with !redir_br cause no action.
//  Op 11 (redir_valid) goes to HALT from any state, except that an outstanding request is first drained.
//  inst_fire = inst_valid & inst_ready & ~redir_take. Decode must qualify acceptance identically.
//  FSM:
//   BOOT: one cycle after rst_n rises -> REQ with imem_addr=RESET_PC.
//   REQ: imem_req=1. imem_addr is held stable until imem_ack; ack may arrive in the same cycle or later.
//     On ack with kill=0: latch inst<=imem_rdata, inst_pc<=pc, inst_pc4<=pc+4; next state OUT.
//     On ack with kill=1: discard the data, clear kill, pc<=pend_tgt; next state REQ.
//     redir_take in REQ without ack: kill<=1, pend_tgt<=target. A later take overwrites pend_tgt (newest wins).
//     redir_take in the same cycle as ack: data discarded; next state REQ at target.
//   OUT: inst_valid=1, imem_req=0.
//     redir_take: inst_valid<=0, pc<=target, next state REQ. The held instruction is squashed and takes priority over inst_ready.
//     inst_fire: inst_valid<=0, pc<=pc+4 (wraps at 2^32), next state REQ.
//     Otherwise hold all outputs.
//   HALT: imem_req=0, inst_valid=0, halted=1; redirects ignored. Exits only via rst_n.
//   Halt with outstanding request: set halt_pend; finish the handshake, discard the data, then enter HALT.
//  Throughput: 1 instruction per 2 cycles with a same-cycle-ack memory. Latency req->inst_valid = ack cycle + 1.
//  imem_ack outside REQ is ignored.
// TESTING
//  1. Reset, RESET_PC=0, same-cycle ack, inst_ready=1 -> imem_addr 0,4,8,C every 2 cycles; inst_pc4 = inst_pc+4.
//  2. In OUT at pc=0x10: redir op=01, redir_pc=0x8, off=0x20 -> held inst squashed; next imem_addr=0x28.
//  3. Ack delayed 3 cycles at addr 0x4 with op=10, br=1, pc=0x0, off=0x40 in wait cycle 1 -> 0x4 data dropped; next addr 0x40; no inst_valid in between.
//  4. op=10, br=0 -> no change; op=01 with target 0x102 -> addr 0x100 and misalign_err 1-cycle pulse.
//  5. pc=0xFFFF_FFFC fired -> next addr 0x0, inst_pc4 of that inst = 0x0; op=11 -> halted=1, no further imem_req.
//  6. Drop rst_n while in REQ -> imem_req=0 immediately; after release first addr = RESET_PC.

Source files
------------

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer for the miniRV core: owns the architectural PC, runs the
// instruction-memory req/ack handshake, presents fetched words to decode and
// applies execute-stage redirects (jump / taken branch / halt).
module fetch_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    input  logic        redir_valid,
    input  logic [1:0]  redir_op,
    input  logic        redir_br,
    input  logic [31:0] redir_pc,
    input  logic [31:0] redir_offset,
    output logic        halted,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_OUT  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [1:0] OP_JUMP = 2'b01;
    localparam logic [1:0] OP_BR   = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_tgt;
    logic        r_kill;
    logic        r_halt_pend;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic [31:0] r_inst_pc4;
    logic        r_misalign;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pend_tgt_nxt;
    logic        w_kill_nxt;
    logic        w_halt_pend_nxt;
    logic [31:0] w_inst_nxt;
    logic [31:0] w_inst_pc_nxt;
    logic [31:0] w_inst_pc4_nxt;
    logic        w_misalign_nxt;

    logic        w_take;
    logic        w_halt_req;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic        w_target_mis;
    logic        w_fire;

    // Redirect decode: taken control flow, halt request and the aligned target.
    always_comb begin
        w_take       = redir_valid & ((redir_op == OP_JUMP) | ((redir_op == OP_BR) & redir_br));
        w_halt_req   = redir_valid & (redir_op == OP_HALT);
        w_target_raw = redir_pc + redir_offset;
        w_target     = {w_target_raw[31:2], 2'b00};
        w_target_mis = (w_target_raw[1:0] != 2'b00);
        w_fire       = inst_valid & inst_ready & ~w_take;
    end

    // Next-state and next-register computation for the fetch FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_pend_tgt_nxt  = r_pend_tgt;
        w_kill_nxt      = r_kill;
        w_halt_pend_nxt = r_halt_pend;
        w_inst_nxt      = r_inst;
        w_inst_pc_nxt   = r_inst_pc;
        w_inst_pc4_nxt  = r_inst_pc4;
        w_misalign_nxt  = 1'b0;

        case (r_state)
            S_BOOT: begin
                w_state_nxt = w_halt_req ? S_HALT : S_REQ;
            end
            S_REQ: begin
                if (imem_ack) begin
                    // Handshake completes this cycle; decide what to do with the data.
                    w_kill_nxt = 1'b0;
                    if (r_halt_pend | w_halt_req) begin
                        w_halt_pend_nxt = 1'b0;
                        w_state_nxt     = S_HALT;
                    end else if (w_take) begin
                        w_pc_nxt       = w_target;
                        w_misalign_nxt = w_target_mis;
                        w_state_nxt    = S_REQ;
                    end else if (r_kill) begin
                        w_pc_nxt    = r_pend_tgt;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_inst_nxt     = imem_rdata;
                        w_inst_pc_nxt  = r_pc;
                        w_inst_pc4_nxt = r_pc + 32'd4;
                        w_state_nxt    = S_OUT;
                    end
                end else if (w_halt_req) begin
                    // Address must stay stable, so the halt waits for the ack.
                    w_halt_pend_nxt = 1'b1;
                end else if (w_take & ~r_halt_pend) begin
                    // Wrong-path fetch in flight: remember the newest target.
                    w_kill_nxt     = 1'b1;
                    w_pend_tgt_nxt = w_target;
                    w_misalign_nxt = w_target_mis;
                end
            end
            S_OUT: begin
                if (w_halt_req) begin
                    w_state_nxt = S_HALT;
                end else if (w_take) begin
                    w_pc_nxt       = w_target;
                    w_misalign_nxt = w_target_mis;
                    w_state_nxt    = S_REQ;
                end else if (w_fire) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = S_REQ;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    // State and datapath registers; everything returns to its boot value on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_BOOT;
            r_pc        <= RESET_PC;
            r_pend_tgt  <= 32'h0;
            r_kill      <= 1'b0;
            r_halt_pend <= 1'b0;
            r_inst      <= 32'h0;
            r_inst_pc   <= 32'h0;
            r_inst_pc4  <= 32'h0;
            r_misalign  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_pend_tgt  <= w_pend_tgt_nxt;
            r_kill      <= w_kill_nxt;
            r_halt_pend <= w_halt_pend_nxt;
            r_inst      <= w_inst_nxt;
            r_inst_pc   <= w_inst_pc_nxt;
            r_inst_pc4  <= w_inst_pc4_nxt;
            r_misalign  <= w_misalign_nxt;
        end
    end

    // Outputs decode directly from state so reset removes the request at once.
    always_comb begin
        imem_req     = (r_state == S_REQ);
        imem_addr    = (r_state == S_REQ) ? r_pc : 32'h0;
        inst_valid   = (r_state == S_OUT);
        halted       = (r_state == S_HALT);
        misalign_err = r_misalign;
        inst         = r_inst;
        inst_pc      = r_inst_pc;
        inst_pc4     = r_inst_pc4;
    end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl: a table of per-cycle vectors for the
// streaming/redirect cases plus hand sequences for delayed ack, PC wrap,
// halt draining and asynchronous reset during a request.
module tb_fetch_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic        redir_valid;
    logic [1:0]  redir_op;
    logic        redir_br;
    logic [31:0] redir_pc;
    logic [31:0] redir_offset;
    logic        halted;
    logic        misalign_err;

    logic        ack_en;
    int          checks;
    int          failures;

    fetch_seq_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_pc4     (inst_pc4),
        .redir_valid  (redir_valid),
        .redir_op     (redir_op),
        .redir_br     (redir_br),
        .redir_pc     (redir_pc),
        .redir_offset (redir_offset),
        .halted       (halted),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model: same-cycle ack whenever enabled.
    assign imem_ack   = imem_req & ack_en;
    assign imem_rdata = mem_word(imem_addr);

    typedef struct {
        logic        rv;
        logic [1:0]  op;
        logic        br;
        logic [31:0] rpc;
        logic [31:0] roff;
        logic        rdy;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic        e_mis;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mkv(input logic rv, input logic [1:0] op, input logic br,
                                 input logic [31:0] rpc, input logic [31:0] roff,
                                 input logic rdy, input logic ack, input logic e_req,
                                 input logic [31:0] e_addr, input logic e_valid,
                                 input logic [31:0] e_ipc, input logic e_mis);
        vec_t v;
        v.rv = rv; v.op = op; v.br = br; v.rpc = rpc; v.roff = roff;
        v.rdy = rdy; v.ack = ack; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_ipc = e_ipc; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_redir();
        redir_valid  = 1'b0;
        redir_op     = 2'b00;
        redir_br     = 1'b0;
        redir_pc     = 32'h0;
        redir_offset = 32'h0;
    endtask

    task automatic redir(input logic [1:0] op, input logic br, input logic [31:0] pc,
                         input logic [31:0] off);
        redir_valid  = 1'b1;
        redir_op     = op;
        redir_br     = br;
        redir_pc     = pc;
        redir_offset = off;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_redir();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        ack_en     = 1'b1;
        inst_ready = 1'b1;
        idle_redir();

        //            rv  op     br  rpc         roff        rdy ack req addr        vld ipc         mis
        vecs[0]  = mkv(0, 2'b00, 0, 32'h0,      32'h0,      1,  1,  1,  32'h0,      0,  32'h0,      0);
        vecs[1]  = mkv(0, 2'b00, 0, 32'h0,      32'h0,      1,  1,  0,  32'h0,      1,  32'h0,      0);
        vecs[2]  = mkv(0, 2'b00, 0, 32'h0,      32'h0,      1,  1,  1,  32'h4,      0,  32'h0,      0);
        vecs[3]  = mkv(0, 2'b00, 0, 32'h0,      32'h0,      1,  1,  0,  32'h0,      1,  32'h4,      0);
        vecs[4]  = mkv(0, 2'b00, 0, 32'h0,      32'h0,      1,  1,  1,  32'h8,      0,  32'h0,      0);
        vecs[5]  = mkv(0, 2'b00, 0, 32'h0,      32'h0,      1,  1,  0,  32'h0,      1,  32'h8,      0);
        vecs[6]  = mkv(0, 2'b00, 0, 32'h0,      32'h0,      1,  1,  1,  32'hC,      0,  32'h0,      0);
        vecs[7]  = mkv(0, 2'b00, 0, 32'h0,      32'h0,      1,  1,  0,  32'h0,      1,  32'hC,      0);
        vecs[8]  = mkv(0, 2'b00, 0, 32'h0,      32'h0,      1,  1,  1,  32'h10,     0,  32'h0,      0);
        vecs[9]  = mkv(0, 2'b00, 0, 32'h0,      32'h0,      0,  1,  0,  32'h0,      1,  32'h10,     0);
        vecs[10] = mkv(1, 2'b01, 0, 32'h8,      32'h20,     1,  1,  1,  32'h28,     0,  32'h0,      0);
        vecs[11] = mkv(0, 2'b00, 0, 32'h0,      32'h0,      0,  1,  0,  32'h0,      1,  32'h28,     0);
        vecs[12] = mkv(1, 2'b10, 0, 32'h0,      32'h100,    0,  1,  0,  32'h0,      1,  32'h28,     0);
        vecs[13] = mkv(1, 2'b01, 0, 32'h100,    32'h2,      0,  1,  1,  32'h100,    0,  32'h0,      1);
        vecs[14] = mkv(0, 2'b00, 0, 32'h0,      32'h0,      0,  1,  0,  32'h0,      1,  32'h100,    0);

        // Outputs while held in reset.
        #2;
        chk("rst_req",   {31'h0, imem_req},     32'h0);
        chk("rst_addr",  imem_addr,             32'h0);
        chk("rst_valid", {31'h0, inst_valid},   32'h0);
        chk("rst_inst",  inst,                  32'h0);
        chk("rst_ipc",   inst_pc,               32'h0);
        chk("rst_ipc4",  inst_pc4,              32'h0);
        chk("rst_halt",  {31'h0, halted},       32'h0);
        chk("rst_mis",   {31'h0, misalign_err}, 32'h0);

        // Streaming, squash-on-redirect, not-taken branch and misaligned jump.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            redir_valid  = vecs[i].rv;
            redir_op     = vecs[i].op;
            redir_br     = vecs[i].br;
            redir_pc     = vecs[i].rpc;
            redir_offset = vecs[i].roff;
            inst_ready   = vecs[i].rdy;
            ack_en       = vecs[i].ack;
            cyc();
            chk($sformatf("v%0d_req", i),   {31'h0, imem_req},     {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i),  imem_addr,             vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'h0, inst_valid},   {31'h0, vecs[i].e_valid});
            chk($sformatf("v%0d_mis", i),   {31'h0, misalign_err}, {31'h0, vecs[i].e_mis});
            chk($sformatf("v%0d_halt", i),  {31'h0, halted},       32'h0);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_ipc", i),  inst_pc,  vecs[i].e_ipc);
                chk($sformatf("v%0d_inst", i), inst,     mem_word(vecs[i].e_ipc));
                chk($sformatf("v%0d_ipc4", i), inst_pc4, vecs[i].e_ipc + 32'd4);
            end
        end

        // Delayed ack with a taken branch arriving during the wait: wrong-path data dropped.
        idle_redir();
        ack_en = 1'b1;
        inst_ready = 1'b1;
        do_reset();
        cyc();
        cyc();
        chk("d_first_ipc", inst_pc, 32'h0);
        ack_en = 1'b0;
        cyc();
        chk("d_addr4", imem_addr, 32'h4);
        redir(2'b10, 1'b1, 32'h0, 32'h40);
        cyc();
        idle_redir();
        chk("d_w1_addr", imem_addr, 32'h4);
        chk("d_w1_req", {31'h0, imem_req}, 32'h1);
        for (int w = 2; w <= 3; w++) begin
            cyc();
            chk($sformatf("d_w%0d_addr", w), imem_addr, 32'h4);
            chk($sformatf("d_w%0d_valid", w), {31'h0, inst_valid}, 32'h0);
        end
        ack_en = 1'b1;
        cyc();
        chk("d_kill_addr", imem_addr, 32'h40);
        chk("d_kill_valid", {31'h0, inst_valid}, 32'h0);
        cyc();
        chk("d_new_valid", {31'h0, inst_valid}, 32'h1);
        chk("d_new_ipc", inst_pc, 32'h40);
        chk("d_new_inst", inst, mem_word(32'h40));

        // PC wrap at 2^32, then halt with an outstanding request.
        inst_ready = 1'b0;
        redir(2'b01, 1'b0, 32'h0, 32'hFFFF_FFFC);
        cyc();
        idle_redir();
        chk("w_addr", imem_addr, 32'hFFFF_FFFC);
        cyc();
        chk("w_ipc", inst_pc, 32'hFFFF_FFFC);
        chk("w_ipc4", inst_pc4, 32'h0);
        inst_ready = 1'b1;
        cyc();
        chk("w_next_addr", imem_addr, 32'h0);
        chk("w_next_req", {31'h0, imem_req}, 32'h1);
        ack_en = 1'b0;
        redir(2'b11, 1'b0, 32'h0, 32'h0);
        cyc();
        idle_redir();
        chk("h_pend_req", {31'h0, imem_req}, 32'h1);
        chk("h_pend_halt", {31'h0, halted}, 32'h0);
        cyc();
        chk("h_pend2_halt", {31'h0, halted}, 32'h0);
        ack_en = 1'b1;
        cyc();
        chk("h_halted", {31'h0, halted}, 32'h1);
        chk("h_valid", {31'h0, inst_valid}, 32'h0);
        redir(2'b01, 1'b0, 32'h0, 32'h40);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("h_stay%0d_req", k), {31'h0, imem_req}, 32'h0);
            chk($sformatf("h_stay%0d_halt", k), {31'h0, halted}, 32'h1);
        end
        idle_redir();

        // Asynchronous reset while a request is outstanding.
        ack_en = 1'b1;
        do_reset();
        cyc();
        cyc();
        cyc();
        chk("r_pre_addr", imem_addr, 32'h4);
        ack_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_async_req", {31'h0, imem_req}, 32'h0);
        chk("r_async_halt", {31'h0, halted}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("r_after_req", {31'h0, imem_req}, 32'h1);
        chk("r_after_addr", imem_addr, 32'h0);
        ack_en = 1'b1;
        cyc();
        chk("r_after_ipc", inst_pc, 32'h0);
        chk("r_after_valid", {31'h0, inst_valid}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
